// File: rtl/scnn_cntl_pkg.sv
// Shared control types for the SCNN PE sequencer: FSM states, flow selection and request record.
package scnn_cntl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    EXEC,
    DRAIN,
    PPU,
    DONE
  } seq_state_e;

  typedef enum logic {
    DENSE  = 1'b0,
    SPARSE = 1'b1
  } flow_e;

  localparam int unsigned REQ_LAYER_W = 8;
  localparam int unsigned REQ_K_W     = 16;
  localparam int unsigned REQ_C_W     = 16;
  localparam int unsigned REQ_PE_W    = 8;

  typedef struct packed {
    logic                   valid;
    logic [REQ_LAYER_W-1:0] layer;
    logic [REQ_K_W-1:0]     k;
    logic [REQ_C_W-1:0]     c;
    logic [REQ_PE_W-1:0]    pe_id;
  } seq_req_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_loop_counter.sv
// Loop index counter: counts 0..bound-1 (a bound of 0 behaves as 1); wrap marks the terminal value.
module pe_loop_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] bound,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q, cnt_d, term;

  always_comb begin
    term  = (bound == '0) ? '0 : bound - W'(1);
    wrap  = (cnt_q == term);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pe_loop_sequencer.sv
// Per-PE k/c/a/w loop-nest sequencer with stream requests, compute beats and PPU handoff.
// Optional cycle counters enabled by defining PE_LOOP_PERF_EN.
module pe_loop_sequencer
  import scnn_cntl_pkg::*;
#(
  parameter int unsigned PE_ID      = 0,
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned K_W        = 6,
  parameter int unsigned C_W        = 8,
  parameter int unsigned A_W        = 10,
  parameter int unsigned W_W        = 6,
  parameter int unsigned DRAIN_CYC  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [K_W-1:0]                      cfg_k_bound,
  input  logic [C_W-1:0]                      cfg_c_bound,
  input  logic [A_W-1:0]                      cfg_a_bound,
  input  logic [W_W-1:0]                      cfg_w_bound,
  input  logic                                ppu_data_flow,
  input  logic [A_W-1:0]                      ppu_num_compr,
  output logic                                req_filter_valid,
  output logic                                req_input_valid,
  output logic [clog2_min1(NUM_LAYERS)-1:0]   req_layer,
  output logic [K_W-1:0]                      req_k,
  output logic [C_W-1:0]                      req_c,
  output logic [$clog2(PE_ID+2)-1:0]          req_pe_id,
  input  logic                                filter_finish,
  input  logic                                input_finish,
  output logic                                beat_valid,
  input  logic                                beat_ready,
  output logic [A_W-1:0]                      beat_a,
  output logic [W_W-1:0]                      beat_w,
  output logic                                beat_last,
  output logic                                ppu_start,
  input  logic                                ppu_done,
  output logic                                busy,
  output logic                                run_done
`ifdef PE_LOOP_PERF_EN
  ,
  output logic [31:0]                         perf_stall_cyc,
  output logic [31:0]                         perf_stream_cyc
`endif
);

  localparam int unsigned LW  = clog2_min1(NUM_LAYERS);
  localparam int unsigned DW  = clog2_min1(DRAIN_CYC);
  localparam int unsigned PW  = $clog2(PE_ID + 2);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = (DRAIN_CYC > 1) ? DW'(DRAIN_CYC - 1) : '0;

  seq_state_e     state_q, state_d;
  logic [LW-1:0]  layer_q, layer_d;
  logic [K_W-1:0] k_bound_q, k_bound_d;
  logic [C_W-1:0] c_bound_q, c_bound_d;
  logic [A_W-1:0] a_bound_q, a_bound_d;
  logic [W_W-1:0] w_bound_q, w_bound_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           filt_seen_q, filt_seen_d;
  logic           inp_seen_q, inp_seen_d;
  logic           ppu_issued_q, ppu_issued_d;
  flow_e          flow;

  logic           cnt_clr, k_inc, c_inc, a_inc, w_inc;
  logic [K_W-1:0] k_cnt;
  logic [C_W-1:0] c_cnt;
  logic [A_W-1:0] a_cnt;
  logic [W_W-1:0] w_cnt;
  logic           k_wrap, c_wrap, a_wrap, w_wrap;
  logic           need_inp;

  pe_loop_counter #(.W(K_W)) u_k (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(k_inc), .bound(k_bound_q), .cnt(k_cnt), .wrap(k_wrap));
  pe_loop_counter #(.W(C_W)) u_c (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(c_inc), .bound(c_bound_q), .cnt(c_cnt), .wrap(c_wrap));
  pe_loop_counter #(.W(A_W)) u_a (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(a_inc), .bound(a_bound_q), .cnt(a_cnt), .wrap(a_wrap));
  pe_loop_counter #(.W(W_W)) u_w (.clk(clk), .rst(rst), .clr(cnt_clr), .inc(w_inc), .bound(w_bound_q), .cnt(w_cnt), .wrap(w_wrap));

  // The input stream is fetched once per run, on the very first (k,c) pass of layer 0.
  assign need_inp = (layer_q == '0) && (k_cnt == '0) && (c_cnt == '0);

  always_comb begin
    state_d          = state_q;
    layer_d          = layer_q;
    k_bound_d        = k_bound_q;
    c_bound_d        = c_bound_q;
    a_bound_d        = a_bound_q;
    w_bound_d        = w_bound_q;
    drain_d          = drain_q;
    filt_seen_d      = 1'b0;
    inp_seen_d       = 1'b0;
    ppu_issued_d     = 1'b0;
    flow             = DENSE;
    cnt_clr          = 1'b0;
    k_inc            = 1'b0;
    c_inc            = 1'b0;
    a_inc            = 1'b0;
    w_inc            = 1'b0;
    req_filter_valid = 1'b0;
    req_input_valid  = 1'b0;
    beat_valid       = 1'b0;
    beat_last        = 1'b0;
    ppu_start        = 1'b0;
    run_done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          layer_d = '0;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        flow      = ((layer_q != '0) && ppu_data_flow) ? SPARSE : DENSE;
        k_bound_d = cfg_k_bound;
        c_bound_d = cfg_c_bound;
        a_bound_d = (flow == SPARSE) ? ppu_num_compr : cfg_a_bound;
        w_bound_d = cfg_w_bound;
        state_d   = STREAM;
      end
      STREAM: begin
        req_filter_valid = !filt_seen_q;
        req_input_valid  = need_inp && !inp_seen_q;
        filt_seen_d      = filt_seen_q | filter_finish;
        inp_seen_d       = inp_seen_q | input_finish;
        if (filt_seen_d && (inp_seen_d || !need_inp)) begin
          state_d     = EXEC;
          filt_seen_d = 1'b0;
          inp_seen_d  = 1'b0;
        end
      end
      EXEC: begin
        beat_valid = 1'b1;
        beat_last  = a_wrap && w_wrap;
        if (beat_ready) begin
          w_inc = 1'b1;
          a_inc = w_wrap;
          if (beat_last) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          c_inc   = 1'b1;
          k_inc   = c_wrap;
          state_d = (c_wrap && k_wrap) ? PPU : STREAM;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      PPU: begin
        ppu_start    = !ppu_issued_q;
        ppu_issued_d = 1'b1;
        if (ppu_done) begin
          ppu_issued_d = 1'b0;
          if (layer_q == LAST_LAYER) begin
            state_d = DONE;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        run_done = 1'b1;
        layer_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      layer_q      <= '0;
      k_bound_q    <= '0;
      c_bound_q    <= '0;
      a_bound_q    <= '0;
      w_bound_q    <= '0;
      drain_q      <= '0;
      filt_seen_q  <= 1'b0;
      inp_seen_q   <= 1'b0;
      ppu_issued_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      k_bound_q    <= k_bound_d;
      c_bound_q    <= c_bound_d;
      a_bound_q    <= a_bound_d;
      w_bound_q    <= w_bound_d;
      drain_q      <= drain_d;
      filt_seen_q  <= filt_seen_d;
      inp_seen_q   <= inp_seen_d;
      ppu_issued_q <= ppu_issued_d;
    end
  end

  assign req_layer = layer_q;
  assign req_k     = k_cnt;
  assign req_c     = c_cnt;
  assign req_pe_id = PW'(PE_ID);
  assign beat_a    = a_cnt;
  assign beat_w    = w_cnt;
  assign busy      = (state_q != IDLE);

`ifdef PE_LOOP_PERF_EN
  logic [31:0] stall_q, stall_d, strm_q, strm_d;

  always_comb begin
    stall_d = stall_q;
    strm_d  = strm_q;
    if (cnt_clr) begin
      stall_d = '0;
      strm_d  = '0;
    end else begin
      if (beat_valid && !beat_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if ((state_q == STREAM) && (strm_q != '1))        strm_d  = strm_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      strm_q  <= '0;
    end else begin
      stall_q <= stall_d;
      strm_q  <= strm_d;
    end
  end

  assign perf_stall_cyc  = stall_q;
  assign perf_stream_cyc = strm_q;
`endif

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Self-checking bench for pe_loop_sequencer: a loop-nest reference model predicts every request and beat.
module tb_pe_loop_sequencer;

  localparam int unsigned NL   = 2;
  localparam int unsigned DRN  = 4;
  localparam int unsigned PEID = 3;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  cfg_k_bound;
  logic [7:0]  cfg_c_bound;
  logic [9:0]  cfg_a_bound;
  logic [5:0]  cfg_w_bound;
  logic        ppu_data_flow;
  logic [9:0]  ppu_num_compr;
  logic        req_filter_valid, req_input_valid;
  logic [0:0]  req_layer;
  logic [5:0]  req_k;
  logic [7:0]  req_c;
  logic [2:0]  req_pe_id;
  logic        filter_finish, input_finish;
  logic        beat_valid, beat_ready;
  logic [9:0]  beat_a;
  logic [5:0]  beat_w;
  logic        beat_last, ppu_start, ppu_done, busy, run_done;
`ifdef PE_LOOP_PERF_EN
  logic [31:0] perf_stall_cyc, perf_stream_cyc;
`endif

  always #5 clk = ~clk;

  pe_loop_sequencer #(
    .PE_ID(PEID), .NUM_LAYERS(NL), .K_W(6), .C_W(8), .A_W(10), .W_W(6), .DRAIN_CYC(DRN)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_k_bound(cfg_k_bound), .cfg_c_bound(cfg_c_bound), .cfg_a_bound(cfg_a_bound),
    .cfg_w_bound(cfg_w_bound), .ppu_data_flow(ppu_data_flow), .ppu_num_compr(ppu_num_compr),
    .req_filter_valid(req_filter_valid), .req_input_valid(req_input_valid),
    .req_layer(req_layer), .req_k(req_k), .req_c(req_c), .req_pe_id(req_pe_id),
    .filter_finish(filter_finish), .input_finish(input_finish),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_a(beat_a), .beat_w(beat_w),
    .beat_last(beat_last), .ppu_start(ppu_start), .ppu_done(ppu_done),
    .busy(busy), .run_done(run_done)
`ifdef PE_LOOP_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_stream_cyc(perf_stream_cyc)
`endif
  );

  typedef struct { int unsigned layer; int unsigned k; int unsigned c; bit inp; } req_t;
  typedef struct { int unsigned a; int unsigned w; bit last; } beat_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  req_t        rq[$];
  beat_t       bq[$];
  int unsigned kb[NL], cb[NL], ab[NL], wb[NL], nc[NL];
  bit          sp[NL];
  int unsigned tb_layer;
  int unsigned tot_beats, tot_passes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned eff(input int unsigned b);
    return (b == 0) ? 1 : b;
  endfunction

  // Expected run: every (layer,k,c) pass in order, each followed by its a-outer/w-inner beat list.
  task automatic build_model();
    int unsigned ka, ca, aa, wa;
    rq.delete();
    bq.delete();
    tot_beats  = 0;
    tot_passes = 0;
    for (int unsigned l = 0; l < NL; l++) begin
      ka = eff(kb[l]);
      ca = eff(cb[l]);
      wa = eff(wb[l]);
      aa = (l != 0 && sp[l]) ? eff(nc[l]) : eff(ab[l]);
      tot_beats  += ka * ca * aa * wa;
      tot_passes += ka * ca;
      for (int unsigned k = 0; k < ka; k++)
        for (int unsigned c = 0; c < ca; c++) begin
          rq.push_back('{l, k, c, (l == 0 && k == 0 && c == 0)});
          for (int unsigned a = 0; a < aa; a++)
            for (int unsigned w = 0; w < wa; w++)
              bq.push_back('{a, w, (a == aa - 1 && w == wa - 1)});
        end
    end
  endtask

  task automatic drive_cfg();
    int unsigned l;
    l = (tb_layer < NL) ? tb_layer : NL - 1;
    cfg_k_bound   = 6'(kb[l]);
    cfg_c_bound   = 8'(cb[l]);
    cfg_a_bound   = 10'(ab[l]);
    cfg_w_bound   = 6'(wb[l]);
    ppu_data_flow = sp[l];
    ppu_num_compr = 10'(nc[l]);
  endtask

  task automatic rand_cfg();
    for (int unsigned l = 0; l < NL; l++) begin
      kb[l] = $urandom_range(1, 2);
      cb[l] = $urandom_range(0, 3);
      ab[l] = $urandom_range(0, 4);
      wb[l] = $urandom_range(0, 3);
      sp[l] = 1'($urandom_range(0, 1));
      nc[l] = $urandom_range(0, 6);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {req_filter_valid, req_input_valid, beat_valid, beat_last, ppu_start, busy, run_done}, 0);
    chk({tag, "_req"}, {req_layer, req_k, req_c}, 0);
    chk({tag, "_beat"}, {beat_a, beat_w}, 0);
  endtask

  task automatic start_run();
    tb_layer = 0;
    drive_cfg();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_no_req", req_filter_valid, 0);
    chk("load_busy", busy, 1);
  endtask

  // Plays stream arbiter, datapath and PPU cycle by cycle, checking the DUT against the model queues.
  task automatic run_env(input int unsigned budget, input int unsigned ready_mode, input int fix_f,
                         input int fix_i, input int unsigned abort_beats, input int unsigned poke_cyc);
    int unsigned cyc = 0, beats = 0, lasts = 0, ppus = 0, rq_age = 0, f_at = 0, i_at = 0;
    int unsigned since_last = 0, ppu_dly = 0;
    bit fin = 0, in_req = 0, need_i = 0, f_sent = 0, i_sent = 0, exp_exec = 0, after_last = 0, ppu_pend = 0;
    req_t  r;
    beat_t b;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      filter_finish = 1'b0;
      input_finish  = 1'b0;
      ppu_done      = 1'b0;
      start         = 1'b0;
      if (cyc == 1) chk("start_latency", req_filter_valid, 1);
      if (poke_cyc != 0 && cyc == poke_cyc) begin
        chk("poke_busy", busy, 1);
        start = 1'b1;
      end

      if (exp_exec) begin
        chk("exec_entry", beat_valid, 1);
        exp_exec = 0;
      end else if (in_req) begin
        chk("exec_early", beat_valid, 0);
      end

      if (after_last) begin
        since_last++;
        if (since_last <= DRN) chk("drain_quiet", {req_filter_valid, ppu_start, beat_valid}, 0);
        else begin
          chk("drain_exit", req_filter_valid | ppu_start, 1);
          after_last = 0;
        end
      end

      if (req_filter_valid && !in_req) begin
        if (rq.size() == 0) chk("req_extra", req_filter_valid, 0);
        else begin
          r = rq.pop_front();
          chk("req_layer", req_layer, r.layer);
          chk("req_k", req_k, r.k);
          chk("req_c", req_c, r.c);
          chk("req_input", req_input_valid, r.inp);
          chk("req_pe_id", req_pe_id, PEID);
          in_req = 1; need_i = r.inp; f_sent = 0; i_sent = 0; rq_age = 0;
          f_at = (fix_f >= 0) ? fix_f : $urandom_range(0, 3);
          i_at = (fix_i >= 0) ? fix_i : $urandom_range(0, 3);
        end
      end
      if (in_req) begin
        if (!f_sent) chk("filt_hold", req_filter_valid, 1);
        else         chk("filt_drop", req_filter_valid, 0);
        if (need_i) begin
          if (!i_sent) chk("inp_hold", req_input_valid, 1);
          else         chk("inp_drop", req_input_valid, 0);
        end else begin
          chk("inp_none", req_input_valid, 0);
        end
        if (!f_sent && rq_age == f_at) begin filter_finish = 1'b1; f_sent = 1; end
        if (need_i && !i_sent && rq_age == i_at) begin input_finish = 1'b1; i_sent = 1; end
        if (f_sent && (i_sent || !need_i)) begin in_req = 0; exp_exec = 1; end
        rq_age++;
      end

      if (ready_mode == 0)      beat_ready = 1'b1;
      else if (ready_mode == 1) beat_ready = 1'(cyc % 2);
      else                      beat_ready = 1'($urandom_range(0, 1));
      if (beat_valid) begin
        if (bq.size() == 0) chk("beat_extra", beat_valid, 0);
        else begin
          b = bq[0];
          chk("beat_a", beat_a, b.a);
          chk("beat_w", beat_w, b.w);
          chk("beat_last", beat_last, b.last);
          if (beat_ready) begin
            b = bq.pop_front();
            beats++;
            if (b.last) begin lasts++; after_last = 1; since_last = 0; end
            if (abort_beats != 0 && beats == abort_beats) fin = 1;
          end
        end
      end

      if (ppu_pend) chk("ppu_pulse", ppu_start, 0);
      else if (ppu_start) begin
        ppus++;
        chk("ppu_layer", req_layer, tb_layer);
        ppu_pend = 1;
        ppu_dly  = $urandom_range(0, 2);
      end
      if (ppu_pend) begin
        if (ppu_dly == 0) begin
          ppu_done = 1'b1;
          ppu_pend = 0;
          tb_layer++;
          drive_cfg();
        end else begin
          ppu_dly--;
        end
      end

      if (run_done) fin = 1;
    end
    chk("run_timeout", fin, 1);
    if (abort_beats == 0) begin
      chk("req_left", rq.size(), 0);
      chk("beat_left", bq.size(), 0);
      chk("ppu_count", ppus, NL);
      chk("beat_count", beats, tot_beats);
      chk("last_count", lasts, tot_passes);
      @(negedge clk);
      chk("idle_after", {busy, run_done}, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; filter_finish = 1'b0; input_finish = 1'b0;
    beat_ready = 1'b0; ppu_done = 1'b0; tb_layer = 0;
    kb = '{2, 1}; cb = '{2, 2}; ab = '{3, 9}; wb = '{2, 2}; sp = '{1'b0, 1'b1}; nc = '{0, 5};
    drive_cfg();
    repeat (3) @(negedge clk);
    chk_quiet("reset_state");
    rst = 1'b0;

    // Dense layer 0 (2x2 passes of 3x2 beats), sparse layer 1 with 5 compressed vectors;
    // layer-0 input finish arrives 3 cycles after filter finish.
    build_model();
    start_run();
    run_env(5000, 0, 0, 3, 0, 0);

    // w bound 0, layer-0 sparse flag ignored, ready toggling, start pulse while busy.
    kb = '{1, 2}; cb = '{3, 1}; ab = '{2, 0}; wb = '{0, 0}; sp = '{1'b1, 1'b0}; nc = '{7, 4};
    build_model();
    start_run();
    run_env(5000, 1, -1, -1, 0, 8);

    for (int unsigned it = 0; it < 3; it++) begin
      rand_cfg();
      build_model();
      start_run();
      run_env(8000, 2, -1, -1, 0, 5 + it);
    end

    // Reset in the middle of EXEC, then a fresh run must begin again at layer 0, k=0, c=0.
    kb = '{2, 1}; cb = '{2, 2}; ab = '{3, 9}; wb = '{2, 2}; sp = '{1'b0, 1'b1}; nc = '{0, 5};
    build_model();
    start_run();
    run_env(5000, 0, 1, 1, 3, 0);
    rst = 1'b1;
    beat_ready = 1'b0; filter_finish = 1'b0; input_finish = 1'b0; ppu_done = 1'b0;
    @(negedge clk);
    chk_quiet("reset_mid_exec");
    rst = 1'b0;
    build_model();
    start_run();
    run_env(5000, 2, -1, -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
